// File: rtl/mac_lane_array.sv
// LANES-wide signed fixed-point MAC with sticky overflow and registered cross-lane sum.
// Result 2 enabled cycles after in_valid, sum 3; ena=0 freezes all state, clr wins over everything.
module mac_lane_array #(
  parameter int LANES    = 4,
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 40,
  parameter bit SATURATE = 1'b1
) (
  input  logic                                clk0,
  input  logic                                clr0_n,
  input  logic                                ena,
  input  logic                                clr,
  input  logic                                in_valid,
  input  logic                                accumulate,
  input  logic [LANES*DATA_W-1:0]             ay,
  input  logic [LANES*DATA_W-1:0]             az,
  output logic                                out_valid,
  output logic [LANES*ACC_W-1:0]              result,
  output logic [LANES-1:0]                    ovf,
  output logic                                sum_valid,
  output logic [ACC_W+$clog2(LANES)-1:0]      sum
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int EXT_W  = ACC_W + 1;
  localparam int SUM_W  = ACC_W + $clog2(LANES);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  generate
    if (ACC_W < PROD_W) begin : g_bad_acc_w
      $error("mac_lane_array: ACC_W must be at least 2*DATA_W");
    end
    if (LANES < 1) begin : g_bad_lanes
      $error("mac_lane_array: LANES must be at least 1");
    end
  endgenerate

  logic signed [PROD_W-1:0] p_q   [LANES];
  logic signed [PROD_W-1:0] p_d   [LANES];
  logic signed [ACC_W-1:0]  acc_q [LANES];
  logic signed [ACC_W-1:0]  acc_d [LANES];
  logic signed [EXT_W-1:0]  tru   [LANES];
  logic [LANES-1:0]         lane_ovf;
  logic [LANES-1:0]         ovf_q, ovf_d;
  logic                     v1_q, v1_d, a1_q, a1_d;
  logic                     out_valid_q, out_valid_d;
  logic                     sum_valid_q, sum_valid_d;
  logic signed [SUM_W-1:0]  sum_q, sum_d, sum_all;

  // One extra bit holds the exact sum; overflow shows up as the top two bits disagreeing.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign tru[g]      = EXT_W'(acc_q[g]) + EXT_W'(p_q[g]);
    assign lane_ovf[g] = tru[g][ACC_W] ^ tru[g][ACC_W-1];
    assign result[g*ACC_W +: ACC_W] = acc_q[g];
  end

  always_comb begin
    sum_all = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_all = sum_all + SUM_W'(acc_q[i]);
    end
  end

  always_comb begin
    p_d         = p_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    v1_d        = v1_q;
    a1_d        = a1_q;
    out_valid_d = out_valid_q;
    sum_valid_d = sum_valid_q;
    sum_d       = sum_q;
    if (clr) begin
      for (int i = 0; i < LANES; i++) begin
        p_d[i]   = '0;
        acc_d[i] = '0;
      end
      ovf_d       = '0;
      v1_d        = 1'b0;
      a1_d        = 1'b0;
      out_valid_d = 1'b0;
      sum_valid_d = 1'b0;
      sum_d       = '0;
    end else if (ena) begin
      for (int i = 0; i < LANES; i++) begin
        p_d[i] = PROD_W'($signed(ay[i*DATA_W +: DATA_W])) * PROD_W'($signed(az[i*DATA_W +: DATA_W]));
        if (v1_q) begin
          if (!a1_q) begin
            acc_d[i] = ACC_W'(p_q[i]);
          end else if (lane_ovf[i]) begin
            ovf_d[i] = 1'b1;
            if (SATURATE) acc_d[i] = tru[i][ACC_W] ? ACC_MIN : ACC_MAX;
            else          acc_d[i] = tru[i][ACC_W-1:0];
          end else begin
            acc_d[i] = tru[i][ACC_W-1:0];
          end
        end
      end
      v1_d        = in_valid;
      a1_d        = accumulate;
      out_valid_d = v1_q;
      sum_d       = sum_all;
      sum_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk0 or negedge clr0_n) begin
    if (!clr0_n) begin
      for (int i = 0; i < LANES; i++) begin
        p_q[i]   <= '0;
        acc_q[i] <= '0;
      end
      ovf_q       <= '0;
      v1_q        <= 1'b0;
      a1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      sum_valid_q <= 1'b0;
      sum_q       <= '0;
    end else begin
      p_q         <= p_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      v1_q        <= v1_d;
      a1_q        <= a1_d;
      out_valid_q <= out_valid_d;
      sum_valid_q <= sum_valid_d;
      sum_q       <= sum_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign sum_valid = sum_valid_q;
  assign sum       = sum_q;

endmodule

// File: tb/tb_mac_lane_array.sv
// Directed + random bench for mac_lane_array: three instances (40-bit saturating, 32-bit
// saturating, 32-bit wrapping) share stimulus; a behavioural model feeds a result scoreboard.
module tb_mac_lane_array;

  typedef struct {
    logic [159:0] r40;
    logic [127:0] rs;
    logic [127:0] rw;
    logic [3:0]   o40;
    logic [3:0]   os;
    logic [3:0]   ow;
    logic [41:0]  s40;
    logic [33:0]  ss;
    logic [33:0]  sw;
    int           cyc;
  } res_t;

  localparam logic [63:0] L4321 = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [63:0] ONES  = {4{16'd1}};
  localparam logic [63:0] TH    = {4{16'd3}};
  localparam logic [63:0] TW    = {4{16'd2}};
  localparam logic [63:0] JUNK  = {16'h7123, 16'h8456, 16'h1234, 16'hFEDC};
  localparam logic [63:0] OVA   = {16'd1, 16'd1, 16'h8000, 16'h8000};
  localparam logic [63:0] OVB   = {16'd1, 16'd1, 16'h7FFF, 16'h8000};

  logic         clk0 = 1'b0;
  logic         clr0_n, ena, clr, in_valid, accumulate;
  logic [63:0]  ay, az;
  logic         ov40, ovs, ovw, sv40, svs, svw;
  logic [159:0] r40;
  logic [127:0] rs, rw;
  logic [3:0]   o40, os, ow;
  logic [41:0]  s40;
  logic [33:0]  ss, sw;

  mac_lane_array #(.LANES(4), .DATA_W(16), .ACC_W(40), .SATURATE(1'b1)) u_dut40 (
    .clk0(clk0), .clr0_n(clr0_n), .ena(ena), .clr(clr), .in_valid(in_valid),
    .accumulate(accumulate), .ay(ay), .az(az), .out_valid(ov40), .result(r40),
    .ovf(o40), .sum_valid(sv40), .sum(s40));
  mac_lane_array #(.LANES(4), .DATA_W(16), .ACC_W(32), .SATURATE(1'b1)) u_sat32 (
    .clk0(clk0), .clr0_n(clr0_n), .ena(ena), .clr(clr), .in_valid(in_valid),
    .accumulate(accumulate), .ay(ay), .az(az), .out_valid(ovs), .result(rs),
    .ovf(os), .sum_valid(svs), .sum(ss));
  mac_lane_array #(.LANES(4), .DATA_W(16), .ACC_W(32), .SATURATE(1'b0)) u_wrap32 (
    .clk0(clk0), .clr0_n(clr0_n), .ena(ena), .clr(clr), .in_valid(in_valid),
    .accumulate(accumulate), .ay(ay), .az(az), .out_valid(ovw), .result(rw),
    .ovf(ow), .sum_valid(svw), .sum(sw));

  always #5 clk0 = ~clk0;

  int         n_chk  = 0;
  int         n_pass = 0;
  int         ecyc   = 0;
  res_t       q[$];
  res_t       cur;
  logic       ov_e, sv_e;
  logic [41:0] s40_e;
  logic [33:0] ss_e, sw_e;
  longint     m40[4], ms[4], mw[4];
  logic [3:0] mo40, mos, mow;
  logic [63:0] ra, rb;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic void lane_upd(input longint p, input bit accm, input int accw, input bit sat,
                                   input longint acc_in, output longint acc_out, output bit ov);
    longint one = 1;
    longint mx  = (one << (accw - 1)) - 1;
    longint mn  = -(one << (accw - 1));
    longint t;
    ov = 1'b0;
    if (!accm) begin
      acc_out = p;
    end else begin
      t = acc_in + p;
      if (t > mx || t < mn) begin
        ov = 1'b1;
        if (sat)        acc_out = (t > mx) ? mx : mn;
        else if (t > mx) acc_out = t - (mx - mn + 1);
        else            acc_out = t + (mx - mn + 1);
      end else begin
        acc_out = t;
      end
    end
  endfunction

  task automatic push_op(input bit acm, input logic [63:0] a, input logic [63:0] b);
    res_t   e;
    longint p, nv, t1, t2, t3;
    bit     ov;
    t1 = 0; t2 = 0; t3 = 0;
    for (int i = 0; i < 4; i++) begin
      p = longint'($signed(a[i*16 +: 16])) * longint'($signed(b[i*16 +: 16]));
      lane_upd(p, acm, 40, 1'b1, m40[i], nv, ov); m40[i] = nv; if (ov) mo40[i] = 1'b1;
      lane_upd(p, acm, 32, 1'b1, ms[i], nv, ov);  ms[i]  = nv; if (ov) mos[i]  = 1'b1;
      lane_upd(p, acm, 32, 1'b0, mw[i], nv, ov);  mw[i]  = nv; if (ov) mow[i]  = 1'b1;
      e.r40[i*40 +: 40] = m40[i][39:0];
      e.rs[i*32 +: 32]  = ms[i][31:0];
      e.rw[i*32 +: 32]  = mw[i][31:0];
      t1 += m40[i]; t2 += ms[i]; t3 += mw[i];
    end
    e.o40 = mo40; e.os = mos; e.ow = mow;
    e.s40 = t1[41:0]; e.ss = t2[33:0]; e.sw = t3[33:0];
    e.cyc = ecyc + 2;
    q.push_back(e);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m40[i] = 0; ms[i] = 0; mw[i] = 0;
    end
    mo40 = '0; mos = '0; mow = '0;
    q.delete();
    cur.r40 = '0; cur.rs = '0; cur.rw = '0;
    cur.o40 = '0; cur.os = '0; cur.ow = '0;
    cur.s40 = '0; cur.ss = '0; cur.sw = '0; cur.cyc = 0;
    ov_e = 1'b0; sv_e = 1'b0;
    s40_e = '0; ss_e = '0; sw_e = '0;
  endtask

  task automatic check_all(input string w);
    chk({w, ".out_valid40"}, ov40, ov_e);
    chk({w, ".out_valid_s"}, ovs, ov_e);
    chk({w, ".out_valid_w"}, ovw, ov_e);
    chk({w, ".result40"}, r40, cur.r40);
    chk({w, ".result_s"}, rs, cur.rs);
    chk({w, ".result_w"}, rw, cur.rw);
    chk({w, ".ovf40"}, o40, cur.o40);
    chk({w, ".ovf_s"}, os, cur.os);
    chk({w, ".ovf_w"}, ow, cur.ow);
    chk({w, ".sum_valid40"}, sv40, sv_e);
    chk({w, ".sum_valid_s"}, svs, sv_e);
    chk({w, ".sum_valid_w"}, svw, sv_e);
    chk({w, ".sum40"}, s40, s40_e);
    chk({w, ".sum_s"}, ss, ss_e);
    chk({w, ".sum_w"}, sw, sw_e);
  endtask

  task automatic step(input string w, input bit e, input bit c, input bit v, input bit acm,
                      input logic [63:0] a, input logic [63:0] b);
    ena = e; clr = c; in_valid = v; accumulate = acm; ay = a; az = b;
    if (e && !c && v) push_op(acm, a, b);
    @(posedge clk0);
    #1;
    if (c) begin
      model_clear();
    end else if (e) begin
      ecyc++;
      s40_e = cur.s40; ss_e = cur.ss; sw_e = cur.sw;
      sv_e  = ov_e;
      ov_e  = (q.size() > 0) && (q[0].cyc == ecyc);
      if (ov_e) cur = q.pop_front();
    end
    check_all(w);
  endtask

  task automatic areset_pulse();
    #1 clr0_n = 1'b0;
    #1;
    model_clear();
    check_all("async_reset");
    #1 clr0_n = 1'b1;
  endtask

  initial begin
    clr0_n = 1'b0; ena = 1'b1; clr = 1'b0; in_valid = 1'b1; accumulate = 1'b1;
    ay = L4321; az = ONES;
    model_clear();
    repeat (3) begin
      @(posedge clk0);
      #1;
      check_all("reset");
    end
    @(negedge clk0);
    clr0_n = 1'b1;
    repeat (2) step("post_reset", 1, 0, 0, 0, '0, '0);

    // Single load, then let result and sum drain.
    step("load", 1, 0, 1, 0, L4321, ONES);
    repeat (3) step("load_drain", 1, 0, 0, 0, '0, '0);

    // Back-to-back accumulate chain ending in a load.
    step("clr_a", 1, 1, 0, 0, '0, '0);
    repeat (3) step("chain", 1, 0, 1, 1, TH, TH);
    step("chain_load", 1, 0, 1, 0, TW, TW);
    repeat (3) step("chain_drain", 1, 0, 0, 0, '0, '0);

    // Same chain with a 3-cycle stall while operations are in flight.
    step("clr_b", 1, 1, 0, 0, '0, '0);
    repeat (2) step("stall_chain", 1, 0, 1, 1, TH, TH);
    repeat (3) step("stall", 0, 0, 1, 1, JUNK, JUNK);
    step("stall_chain", 1, 0, 1, 1, TH, TH);
    step("stall_load", 1, 0, 1, 0, TW, TW);
    repeat (3) step("stall_drain", 1, 0, 0, 0, '0, '0);

    // Overflow: lane 0 goes positive, lane 1 goes negative on the third add.
    step("clr_c", 1, 1, 0, 0, '0, '0);
    step("ovf_load", 1, 0, 1, 0, OVA, OVB);
    step("ovf_acc", 1, 0, 1, 1, OVA, OVB);
    repeat (3) step("ovf_drain", 1, 0, 0, 0, '0, '0);
    step("ovf_acc2", 1, 0, 1, 1, OVA, OVB);
    repeat (3) step("ovf_hold", 1, 0, 0, 0, '0, '0);
    step("ovf_load_keep", 1, 0, 1, 0, ONES, ONES);
    repeat (3) step("ovf_sticky", 1, 0, 0, 0, '0, '0);
    step("clr_noena", 0, 1, 0, 0, '0, '0);
    repeat (2) step("after_clr_noena", 1, 0, 0, 0, '0, '0);

    // Synchronous clear colliding with a valid op, then restart from zero.
    repeat (2) step("mid_chain", 1, 0, 1, 1, TH, TH);
    step("clr_mid", 1, 1, 1, 1, TH, TH);
    step("after_clr", 1, 0, 1, 1, TH, TH);
    repeat (3) step("after_clr_drain", 1, 0, 0, 0, '0, '0);

    // Asynchronous reset pulse mid-stream.
    repeat (2) step("pre_arst", 1, 0, 1, 1, TH, TH);
    areset_pulse();
    step("after_arst", 1, 0, 1, 1, TH, TH);
    repeat (3) step("after_arst_drain", 1, 0, 0, 0, '0, '0);

    // Random mix of stalls, loads, accumulates, signed operands and occasional clears.
    for (int k = 0; k < 60; k++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      step("random", $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, ra, rb);
    end
    repeat (4) step("final_drain", 1, 0, 0, 0, '0, '0);
    chk("scoreboard_empty", 256'(q.size()), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
